// File: rtl/fsm_msi_requests_controler.sv
// Per-block MSI coherence controller: a CPU-request FSM and a snooped-bus-request FSM, both registered.
// Optional MSI_PROTOCOL_CHECK_EN adds a registered protocol_error pulse to each FSM.

module fsm_msi_cpu_requests_controler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] state,
    input  logic       cpu_read_hit,
    input  logic       cpu_read_miss,
    input  logic       cpu_write_hit,
    input  logic       cpu_write_miss,
    output logic       write_back_block,
    output logic [1:0] state_out,
    output logic [1:0] bus_out
`ifdef MSI_PROTOCOL_CHECK_EN
    ,output logic      protocol_error
`endif
);
    typedef enum logic [1:0] {ST_I = 2'b00, ST_S = 2'b01, ST_M = 2'b10} msi_e;

    localparam logic [1:0] BUS_NONE = 2'b00;
    localparam logic [1:0] BUS_RDMS = 2'b01;
    localparam logic [1:0] BUS_WRMS = 2'b10;
    localparam logic [1:0] BUS_INV  = 2'b11;

    msi_e       w_cur;
    msi_e       w_next;
    logic [1:0] w_bus;
    logic       w_wb;

    // The illegal encoding is folded onto Invalid before any decision.
    assign w_cur = (state == 2'b11) ? ST_I : msi_e'(state);

    always_comb begin
        w_next = w_cur;
        w_bus  = BUS_NONE;
        w_wb   = 1'b0;
        if (cpu_write_miss) begin
            w_next = ST_M;
            w_bus  = BUS_WRMS;
            w_wb   = (w_cur == ST_M);
        end else if (cpu_read_miss) begin
            w_next = ST_S;
            w_bus  = BUS_RDMS;
            w_wb   = (w_cur == ST_M);
        end else if (cpu_write_hit) begin
            case (w_cur)
                ST_S: begin
                    w_next = ST_M;
                    w_bus  = BUS_INV;
                end
                ST_M:    w_next = ST_M;
                default: w_next = ST_I;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_out        <= 2'b00;
            bus_out          <= BUS_NONE;
            write_back_block <= 1'b0;
        end else begin
            state_out        <= w_next;
            bus_out          <= w_bus;
            write_back_block <= w_wb;
        end
    end

`ifdef MSI_PROTOCOL_CHECK_EN
    logic [3:0] w_req;
    logic       w_err;

    assign w_req = {cpu_read_hit, cpu_read_miss, cpu_write_hit, cpu_write_miss};
    assign w_err = ((w_req & (w_req - 4'd1)) != 4'd0) || (state == 2'b11) ||
                   ((state == 2'b00) && (cpu_read_hit || cpu_write_hit));

    always_ff @(posedge clk) begin
        if (!rst_n) protocol_error <= 1'b0;
        else        protocol_error <= w_err;
    end
`endif
endmodule

module fsm_msi_bus_requests_controler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] state,
    input  logic       bus_read_miss,
    input  logic       bus_write_miss,
    input  logic       bus_invalidate,
    output logic       abort_mem_access,
    output logic       write_back_block,
    output logic [1:0] state_out
`ifdef MSI_PROTOCOL_CHECK_EN
    ,output logic      protocol_error
`endif
);
    typedef enum logic [1:0] {ST_I = 2'b00, ST_S = 2'b01, ST_M = 2'b10} msi_e;

    msi_e w_cur;
    msi_e w_next;
    logic w_flush;

    assign w_cur = (state == 2'b11) ? ST_I : msi_e'(state);

    // A Modified block snooped by a miss is supplied by this cache, so the
    // write-back and the memory abort always travel together.
    always_comb begin
        w_next  = w_cur;
        w_flush = 1'b0;
        if (bus_write_miss) begin
            w_next  = ST_I;
            w_flush = (w_cur == ST_M);
        end else if (bus_invalidate) begin
            if (w_cur == ST_S) w_next = ST_I;
        end else if (bus_read_miss) begin
            if (w_cur == ST_M) begin
                w_next  = ST_S;
                w_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_out        <= 2'b00;
            abort_mem_access <= 1'b0;
            write_back_block <= 1'b0;
        end else begin
            state_out        <= w_next;
            abort_mem_access <= w_flush;
            write_back_block <= w_flush;
        end
    end

`ifdef MSI_PROTOCOL_CHECK_EN
    logic [2:0] w_req;
    logic       w_err;

    assign w_req = {bus_read_miss, bus_write_miss, bus_invalidate};
    assign w_err = ((w_req & (w_req - 3'd1)) != 3'd0) || (state == 2'b11) ||
                   ((state == 2'b10) && bus_invalidate);

    always_ff @(posedge clk) begin
        if (!rst_n) protocol_error <= 1'b0;
        else        protocol_error <= w_err;
    end
`endif
endmodule

module fsm_msi_requests_controler (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_cpu_state,
    input  logic       i_cpu_read_hit,
    input  logic       i_cpu_read_miss,
    input  logic       i_cpu_write_hit,
    input  logic       i_cpu_write_miss,
    output logic       o_cpu_write_back_block,
    output logic [1:0] o_cpu_state_out,
    output logic [1:0] o_cpu_bus_out,
    input  logic [1:0] i_bus_state,
    input  logic       i_bus_read_miss,
    input  logic       i_bus_write_miss,
    input  logic       i_bus_invalidate,
    output logic       o_bus_abort_mem_access,
    output logic       o_bus_write_back_block,
    output logic [1:0] o_bus_state_out
`ifdef MSI_PROTOCOL_CHECK_EN
    ,output logic      o_cpu_protocol_error
    ,output logic      o_bus_protocol_error
`endif
);
    fsm_msi_cpu_requests_controler u_cpu (
        .clk              (i_clk),
        .rst_n            (i_rst_n),
        .state            (i_cpu_state),
        .cpu_read_hit     (i_cpu_read_hit),
        .cpu_read_miss    (i_cpu_read_miss),
        .cpu_write_hit    (i_cpu_write_hit),
        .cpu_write_miss   (i_cpu_write_miss),
        .write_back_block (o_cpu_write_back_block),
        .state_out        (o_cpu_state_out),
        .bus_out          (o_cpu_bus_out)
`ifdef MSI_PROTOCOL_CHECK_EN
        ,.protocol_error  (o_cpu_protocol_error)
`endif
    );

    fsm_msi_bus_requests_controler u_bus (
        .clk              (i_clk),
        .rst_n            (i_rst_n),
        .state            (i_bus_state),
        .bus_read_miss    (i_bus_read_miss),
        .bus_write_miss   (i_bus_write_miss),
        .bus_invalidate   (i_bus_invalidate),
        .abort_mem_access (o_bus_abort_mem_access),
        .write_back_block (o_bus_write_back_block),
        .state_out        (o_bus_state_out)
`ifdef MSI_PROTOCOL_CHECK_EN
        ,.protocol_error  (o_bus_protocol_error)
`endif
    );
endmodule

// File: tb/tb_fsm_msi_requests_controler.sv
// Scoreboard bench for the MSI controller: expectations are queued as stimulus is
// driven at the falling edge and popped against the registered outputs after the rising edge.

module tb_fsm_msi_requests_controler;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] cst, bst;
    logic       crh, crm, cwh, cwm, brm, bwm, binv;
    logic       cwb, bab, bwb;
    logic [1:0] cso, cbo, bso;
    logic       cpe, bpe;

    always #5 clk = ~clk;

    fsm_msi_requests_controler dut (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_cpu_state            (cst),
        .i_cpu_read_hit         (crh),
        .i_cpu_read_miss        (crm),
        .i_cpu_write_hit        (cwh),
        .i_cpu_write_miss       (cwm),
        .o_cpu_write_back_block (cwb),
        .o_cpu_state_out        (cso),
        .o_cpu_bus_out          (cbo),
        .i_bus_state            (bst),
        .i_bus_read_miss        (brm),
        .i_bus_write_miss       (bwm),
        .i_bus_invalidate       (binv),
        .o_bus_abort_mem_access (bab),
        .o_bus_write_back_block (bwb),
        .o_bus_state_out        (bso)
`ifdef MSI_PROTOCOL_CHECK_EN
        ,.o_cpu_protocol_error  (cpe)
        ,.o_bus_protocol_error  (bpe)
`endif
    );
`ifndef MSI_PROTOCOL_CHECK_EN
    assign cpe = 1'b0;
    assign bpe = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] cs;
        logic [1:0] cb;
        logic       cwb;
        logic       cpe;
        logic [1:0] bs;
        logic       bab;
        logic       bwb;
        logic       bpe;
    } exp_t;

    // Test-plan tables. CPU: {state_out, bus_out, write_back}, columns read_hit,
    // read_miss, write_hit, write_miss. Bus: {state_out, abort, write_back},
    // columns read_miss, write_miss, invalidate.
    localparam logic [4:0] CPU_TBL [3][4] = '{
        '{5'b00000, 5'b01010, 5'b00000, 5'b10100},
        '{5'b01000, 5'b01010, 5'b10110, 5'b10100},
        '{5'b10000, 5'b01011, 5'b10000, 5'b10101}};
    localparam logic [3:0] BUS_TBL [3][3] = '{
        '{4'b0000, 4'b0000, 4'b0000},
        '{4'b0100, 4'b0000, 4'b0000},
        '{4'b0111, 4'b0011, 4'b1000}};

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic exp_t sample();
        exp_t g;
        g = '{cs: cso, cb: cbo, cwb: cwb, cpe: cpe, bs: bso, bab: bab, bwb: bwb, bpe: bpe};
        return g;
    endfunction

    // Reference model: priority-encode the request, then look it up in the tables.
    function automatic exp_t model(input logic r, input logic [1:0] cs_i, input logic [3:0] creq,
                                   input logic [1:0] bs_i, input logic [2:0] breq);
        exp_t e;
        logic [4:0] c;
        logic [3:0] b;
        int s_c, s_b, ci, bi;
        e = '0;
        if (!r) return e;
        s_c = (cs_i == 2'b11) ? 0 : int'(cs_i);
        s_b = (bs_i == 2'b11) ? 0 : int'(bs_i);
        // creq = {read_hit, read_miss, write_hit, write_miss}
        ci = creq[0] ? 3 : creq[2] ? 1 : creq[1] ? 2 : creq[3] ? 0 : -1;
        // breq = {read_miss, write_miss, invalidate}
        bi = breq[1] ? 1 : breq[0] ? 2 : breq[2] ? 0 : -1;
        c = (ci < 0) ? {2'(s_c), 3'b000} : CPU_TBL[s_c][ci];
        b = (bi < 0) ? {2'(s_b), 2'b00} : BUS_TBL[s_b][bi];
        e.cs = c[4:3]; e.cb = c[2:1]; e.cwb = c[0];
        e.bs = b[3:2]; e.bab = b[1];  e.bwb = b[0];
`ifdef MSI_PROTOCOL_CHECK_EN
        e.cpe = ($countones(creq) > 1) || (cs_i == 2'b11) || ((cs_i == 2'b00) && (creq[3] || creq[1]));
        e.bpe = ($countones(breq) > 1) || (bs_i == 2'b11) || ((bs_i == 2'b10) && breq[0]);
`endif
        return e;
    endfunction

    task automatic apply(input logic r, input logic [1:0] cs_i, input logic [3:0] creq,
                         input logic [1:0] bs_i, input logic [2:0] breq, input exp_t e);
        @(negedge clk);
        rst_n = r;
        cst = cs_i; {crh, crm, cwh, cwm} = creq;
        bst = bs_i; {brm, bwm, binv} = breq;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e, g;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 2'(i + 1), 4'b1111 >> i, 2'(i + 1), 3'b111 >> i, '0);
            @(posedge clk); #1;
            e = sb.pop_front(); g = sample(); n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL reset[%0d]: got %h want %h", i, g, e); end
        end
    endtask

    task automatic test_cpu_sweep();
        exp_t e, g;
        for (int s = 0; s < 3; s++)
            for (int r = 0; r < 4; r++) begin
                logic [3:0] req;
                logic [4:0] t;
                req = 4'b1000 >> r;
                t = CPU_TBL[s][r];
                e = '0; e.cs = t[4:3]; e.cb = t[2:1]; e.cwb = t[0];
`ifdef MSI_PROTOCOL_CHECK_EN
                e.cpe = (s == 0) && (r == 0 || r == 2);
`endif
                apply(1'b1, 2'(s), req, 2'b00, 3'b000, e);
                @(posedge clk); #1;
                e = sb.pop_front(); g = sample(); n_cmp++;
                if (g !== e) begin n_fail++; $display("FAIL cpu_sweep s%0d r%0d: got %h want %h", s, r, g, e); end
            end
    endtask

    task automatic test_bus_sweep();
        exp_t e, g;
        for (int s = 0; s < 3; s++)
            for (int r = 0; r < 3; r++) begin
                logic [2:0] req;
                logic [3:0] t;
                req = 3'b100 >> r;
                t = BUS_TBL[s][r];
                e = '0; e.bs = t[3:2]; e.bab = t[1]; e.bwb = t[0];
`ifdef MSI_PROTOCOL_CHECK_EN
                e.bpe = (s == 2) && (r == 2);
`endif
                apply(1'b1, 2'b00, 4'b0000, 2'(s), req, e);
                @(posedge clk); #1;
                e = sb.pop_front(); g = sample(); n_cmp++;
                if (g !== e) begin n_fail++; $display("FAIL bus_sweep s%0d r%0d: got %h want %h", s, r, g, e); end
            end
    endtask

    task automatic test_priority();
        exp_t e, g;
        e = model(1'b1, 2'b01, 4'b0011, 2'b10, 3'b110);
        e.cs = 2'b10; e.cb = 2'b10; e.cwb = 1'b0;
        e.bs = 2'b00; e.bab = 1'b1; e.bwb = 1'b1;
        apply(1'b1, 2'b01, 4'b0011, 2'b10, 3'b110, e);
        @(posedge clk); #1;
        e = sb.pop_front(); g = sample(); n_cmp++;
        if (g !== e) begin n_fail++; $display("FAIL priority: got %h want %h", g, e); end
    endtask

    task automatic test_illegal_state();
        exp_t e, g;
        // State 11 behaves as Invalid; the following idle cycle must clear any error pulse.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] st;
            logic [3:0] cr;
            logic [2:0] br;
            st = (i % 2 == 0) ? 2'b11 : 2'b01;
            cr = (i % 2 == 0) ? 4'b0100 : 4'b0000;
            br = (i % 2 == 0) ? 3'b100 : 3'b000;
            e = model(1'b1, st, cr, st, br);
            apply(1'b1, st, cr, st, br, e);
            @(posedge clk); #1;
            e = sb.pop_front(); g = sample(); n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL illegal_state[%0d]: got %h want %h", i, g, e); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, g;
        for (int i = 0; i < 300; i++) begin
            logic r;
            logic [1:0] cs_i, bs_i;
            logic [3:0] creq;
            logic [2:0] breq;
            r    = ($urandom_range(0, 15) != 0);
            cs_i = 2'($urandom_range(0, 3));
            bs_i = 2'($urandom_range(0, 3));
            creq = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3)) & 4'($urandom_range(0, 15) | 1);
            breq = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b001 << $urandom_range(0, 2);
            e = model(r, cs_i, creq, bs_i, breq);
            apply(r, cs_i, creq, bs_i, breq, e);
            @(posedge clk); #1;
            e = sb.pop_front(); g = sample(); n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL back_to_back[%0d]: got %h want %h", i, g, e); end
        end
    endtask

    initial begin
        rst_n = 1'b0; cst = '0; bst = '0;
        {crh, crm, cwh, cwm, brm, bwm, binv} = '0;
        test_reset();
        test_cpu_sweep();
        test_bus_sweep();
        test_priority();
        test_illegal_state();
        test_back_to_back();
        test_reset();
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
